dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving the CPU FSM Memory stage: the memory end of the LW/SW load/store interface.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, performs a word read or a byte-enabled write, then returns a single-cycle response pulse.
- Word-addressed storage, byte addresses on the port; one outstanding transaction maximum.

Parameters:
- ADDR_W, 10, word-index width; memory holds 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states between acceptance and access (0..15).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store (SW), 0 = load (LW)
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_be  input  4  byte enables, bit i selects wdata[8i+7:8i]
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  load data; 0 for stores and errors
- resp_err  output  1  access faulted; valid only with resp_valid

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Memory array is not reset.
- Reset mid-transaction aborts the transaction. A write not yet committed never lands.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture write, addr, wdata and be into holding registers. Load counter=WAIT_CYCLES, then go to WAIT, or to ACCESS if WAIT_CYCLES=0.
  - WAIT: req_ready=0. Decrement the counter; at count 1 go to ACCESS.
  - ACCESS: req_ready=0. Perform the array read or write in this cycle and register rdata/err. Go to RESP.
  - RESP: resp_valid=1 for exactly this cycle, req_ready=0. Return to IDLE.
- Latency: acceptance edge to resp_valid high = WAIT_CYCLES+2 cycles. Next acceptance is possible one cycle after RESP.
- Request inputs are sampled only at acceptance; later changes are ignored.
- Word index = addr[ADDR_W+1:2].
- Out of range (any addr[31:ADDR_W+2] set): resp_err=1, resp_rdata=0, no write.
- Write: only lanes with be=1 update. be=0000 is a legal no-op with resp_err=0. resp_rdata=0 on writes.
- Read: full 32-bit word; req_be is ignored.
- resp_rdata/resp_err hold their last values between responses; consumers qualify them with resp_valid.
- req_valid while req_ready=0 is ignored (no queueing). The requester holds req_valid until it is accepted.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: addr[1:0]!=00 gives resp_err=1, resp_rdata=0, no write. Same timing as a normal access.
- Undefined: addr[1:0] is ignored, so the access goes to the containing word.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding (IDLE, WAIT, ACCESS, RESP as a 2-bit typedef);
  - WORD_W=32 and BE_W=4;
  - the address-check function (range, and alignment when enabled).
- One sub-module, dmem_array: synchronous single-port 2**ADDR_W x 32 RAM with per-byte write enables and registered read.
- dmem_responder contains only the FSM, counter, holding registers and error logic.

Test Plan:
- Reset, then SW addr 0x00000010 wdata 0xDEADBEEF be 1111, WAIT_CYCLES=2 -> resp_valid exactly 4 cycles after acceptance, err=0. Then LW 0x10 -> rdata 0xDEADBEEF.
- Partial store: write 0x11223344 to 0x20, then SW 0x20 wdata 0xAABBCCDD be 0101 -> LW 0x20 returns 0x11BB33DD.
- Out of range: LW addr 0x00001000 with ADDR_W=10 -> resp_err=1, rdata=0. SW to that address leaves all in-range words unchanged.
- Back-pressure: assert req_valid continuously with changing addresses -> req_ready low from acceptance until after RESP. Only the captured request is served, one resp_valid per acceptance.
- Reset mid-op: SW 0x40 wdata 0x12345678, drop rst_n during WAIT -> outputs return to reset values immediately. A later LW 0x40 returns the prior contents (0x0 after a preload of zeros).
- Misalign: SW 0x42 wdata 0xCAFEF00D -> with DMEM_MISALIGN_ERR_EN, resp_err=1 and word 0x40 unchanged. Without it, resp_err=0 and LW 0x40 returns 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_pkg.sv
// Purpose: shared types, widths and address checking for the data-memory responder.
// Latency: n/a (package: types, constants and one combinational helper).
// Backpressure: n/a.
// Optional feature macro: DMEM_MISALIGN_ERR_EN (misaligned byte addresses fault).
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Faults an access whose byte address lies outside 2**addr_w words,
  // and optionally one that is not word aligned.
  function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
    logic err;
    err = ((addr >> (addr_w + 2)) != 32'd0);
`ifdef DMEM_MISALIGN_ERR_EN
    err = err | (addr[1:0] != 2'b00);
`endif
    return err;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Purpose: single-port 2**ADDR_W x 32 RAM with per-byte write enables.
// Latency: write commits at the clock edge; read data registered, valid after one edge.
// Backpressure: none; one access per enabled cycle.
// Ports: clk; rd (read strobe); we (byte write enables); addr (word index);
//        wdata (write data); rdata (registered read data, held until next read).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rd,
  input  logic [BE_W-1:0]   we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (rd) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: data-memory responder for the CPU memory stage (LW/SW), one transaction at a time.
// Latency: resp_valid pulses WAIT_CYCLES+2 cycles after the acceptance cycle.
// Backpressure: req_ready low from acceptance through RESP; req_valid is ignored meanwhile.
// Ports: clk, rst_n (async active-low); req_valid/req_ready handshake with
//        req_write, req_addr (byte address), req_wdata, req_be; response
//        resp_valid (1-cycle pulse), resp_rdata, resp_err (held between responses).
// Optional feature macro: DMEM_MISALIGN_ERR_EN (see dmem_pkg::addr_err).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              err_q;
  logic              rd_vld_q;   // last response was a successful load
  logic              acc_err;
  logic              accept;
  logic              ram_rd;
  logic [BE_W-1:0]   ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign accept  = req_valid && (state_q == IDLE);
  assign acc_err = addr_err(addr_q, ADDR_W);

  // Faulted accesses never reach the array, so no write can land.
  assign ram_rd = (state_q == ACCESS) && !acc_err && !wr_q;
  assign ram_we = ((state_q == ACCESS) && !acc_err && wr_q) ? be_q : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACCESS;
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (state_q == ACCESS) begin
        err_q    <= acc_err;
        rd_vld_q <= !acc_err && !wr_q;
      end
    end
  end

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .rd    (ram_rd),
    .we    (ram_we),
    .addr  (addr_q[ADDR_W+1:2]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // The array read register only moves on loads, so gating it keeps
  // resp_rdata stable between responses and zero for stores/faults.
  assign resp_rdata = rd_vld_q ? ram_rdata : '0;
  assign resp_err   = err_q;
  assign resp_valid = (state_q == RESP);
  assign req_ready  = (state_q == IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called 1ns after a rising edge with the DUT idle. lat counts rising
  // edges from the acceptance edge (inclusive) to the one raising resp_valid.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clk); #1;
    lat = 1;
    // Scramble the request after acceptance; it must be ignored.
    req_valid = 1'b0; req_write = ~wr; req_addr = 32'hFFFF_FFFC;
    req_wdata = 32'h5555_AAAA; req_be = 4'hF;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic wr_word(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, addr, wd, 4'hF, rd, er, lat);
  endtask

  task automatic rd_word(input logic [31:0] addr, output logic [31:0] rd);
    logic er; int lat;
    do_req(1'b0, addr, 32'h0, 4'h0, rd, er, lat);
  endtask

  initial begin
    logic [31:0] rd, rd0, rd1;
    logic        er, rdy5;
    int          lat, nresp, nlow;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    #22;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word store then load.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("sw_latency", lat, 4);
    check("sw_err", {31'b0, er}, 32'd0);
    check("sw_rdata_zero", rd, 32'h0);
    check("resp_single_pulse", {31'b0, resp_valid}, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("lw_latency", lat, 4);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", {31'b0, er}, 32'd0);

    // Partial store and be=0000 no-op.
    wr_word(32'h20, 32'h11223344);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    rd_word(32'h20, rd);
    check("partial_store", rd, 32'h11BB33DD);
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    check("be0_err", {31'b0, er}, 32'd0);
    rd_word(32'h20, rd);
    check("be0_noop", rd, 32'h11BB33DD);

    // Out of range: 0x1000 would alias word 0 if the check were missing.
    wr_word(32'h0, 32'h5A5A5A5A);
    do_req(1'b0, 32'h1000, 32'h0, 4'hF, rd, er, lat);
    check("oor_lw_err", {31'b0, er}, 32'd1);
    check("oor_lw_rdata", rd, 32'h0);
    do_req(1'b1, 32'h1000, 32'h01020304, 4'hF, rd, er, lat);
    check("oor_sw_err", {31'b0, er}, 32'd1);
    rd_word(32'h0, rd);
    check("oor_word0_kept", rd, 32'h5A5A5A5A);
    rd_word(32'h10, rd);
    check("oor_word10_kept", rd, 32'hDEADBEEF);

    // Back-pressure: req_valid held while the address keeps changing.
    wr_word(32'h50, 32'hA0A0A0A0);
    wr_word(32'h54, 32'hB1B1B1B1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50; req_be = 4'h0;
    @(posedge clk); #1;
    nresp = 0; nlow = 0; rd0 = '0; rd1 = '0; rdy5 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (resp_valid) begin
        if (nresp == 0) rd0 = resp_rdata; else rd1 = resp_rdata;
        nresp++;
      end
      if (!req_ready) nlow++;
      if (c == 5) rdy5 = req_ready;
      req_addr = (c < 5) ? 32'h54 + 32'(c * 4) : 32'h54;
      if (c == 5) req_addr = 32'h54;
      if (c == 4) req_addr = 32'h54;
      if (c == 9) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("bp_resp_count", nresp, 2);
    check("bp_ready_low_cycles", nlow, 8);
    check("bp_ready_after_resp", {31'b0, rdy5}, 32'd1);
    check("bp_first_rdata", rd0, 32'hA0A0A0A0);
    check("bp_second_rdata", rd1, 32'hB1B1B1B1);

    // Reset during WAIT aborts a store.
    wr_word(32'h40, 32'h0);
    rd_word(32'h10, rd);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
    req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("midrst_rdata", resp_rdata, 32'h0);
    check("midrst_err", {31'b0, resp_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rd_word(32'h40, rd);
    check("midrst_no_write", rd, 32'h0);

    // Misaligned store.
    do_req(1'b1, 32'h42, 32'hCAFEF00D, 4'hF, rd, er, lat);
    check("misalign_latency", lat, 4);
    rd_word(32'h40, rd);
`ifdef DMEM_MISALIGN_ERR_EN
    check("misalign_err", {31'b0, er}, 32'd1);
    check("misalign_word", rd, 32'h0);
`else
    check("misalign_err", {31'b0, er}, 32'd0);
    check("misalign_word", rd, 32'hCAFEF00D);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
